// File: rtl/sliced_alu_seq.sv
// sliced_alu_seq: multi-cycle WIDTH-bit ALU built from one reused 4-bit
// 74181-style slice. One nibble is processed per clock, LSB first, with the
// active-low ripple carry held in a register between nibbles.
module sliced_alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cn4,
    output logic             aeqb
);

    localparam int unsigned SLICES = WIDTH / 4;
    localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_d;
    logic             busy_q;
    logic             done_q;
    logic             cn4_q;
    logic             aeqb_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_f;
    logic             nib_co;
    logic             e;
    logic             d;
    logic             cb;

    assign busy = busy_q;
    assign done = done_q;
    assign f    = f_q;
    assign cn4  = cn4_q;
    assign aeqb = aeqb_q;

    // Select the operand nibble addressed by the slice counter
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned k = 0; k < SLICES; k++) begin
            if (cnt_q == CW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
    end

    // 4-bit slice: per-bit E/D terms with an internal active-low ripple carry
    always_comb begin
        cb    = carry_q;
        e     = 1'b0;
        d     = 1'b0;
        nib_f = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            e        = ~(nib_a[i] | (nib_b[i] & s_q[0]) | (~nib_b[i] & s_q[1]));
            d        = ~((nib_a[i] & ~nib_b[i] & s_q[2]) | (nib_a[i] & nib_b[i] & s_q[3]));
            nib_f[i] = e ^ d ^ ~(~m_q & cb);
            cb       = d & (e | cb);
        end
        nib_co = cb;
    end

    // Merge the freshly computed nibble into the result, other nibbles hold
    always_comb begin
        f_d = f_q;
        for (int unsigned k = 0; k < SLICES; k++) begin
            if (cnt_q == CW'(k)) begin
                f_d[4*k +: 4] = nib_f;
            end
        end
    end

    // Sequencer: accept in IDLE/DONE, one nibble per RUN cycle, flags on DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            f_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cn4_q   <= 1'b1;
            aeqb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        s_q     <= s;
                        m_q     <= m;
                        carry_q <= cn;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    f_q     <= f_d;
                    carry_q <= nib_co;
                    cnt_q   <= cnt_q + CW'(1);
                    // Flags are taken from the last nibble's values so they are
                    // valid during the single DONE cycle.
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cn4_q   <= nib_co;
                        aeqb_q  <= &f_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
